counter_ctrl: RTL and testbench

- Front-end control stage that sits directly upstream of the 4-bit up/down counter.
- Turns raw board inputs (up, down and load pushbuttons, 4 data switches) into clean counter controls: single-cycle count enable, direction, load strobe and data word.
- Provides synchronization, per-button debounce, edge detection and auto-repeat while a direction button is held.
- All outputs are registered and drive the counter's load/count_en/up/data_in pins directly.

---
 rtl/counter_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_counter_ctrl.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/counter_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : counter_ctrl
// Description : Front-end control stage for a 4-bit up/down counter. It
//               synchronizes and debounces the raw pushbuttons and switches,
//               detects press edges and generates auto-repeat count strobes.
//               All outputs are registered.
// Revision    : 1.0 - initial release
// ============================================================================
module counter_ctrl #(
    parameter int DEBOUNCE_CYC = 16,
    parameter int REPEAT_DELAY = 64,
    parameter int REPEAT_RATE  = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_up,
    input  logic       btn_dn,
    input  logic       btn_load,
    input  logic [3:0] sw_data,
    output logic       load,
    output logic       count_en,
    output logic       up,
    output logic [3:0] data_in
);

    // Button slots inside the packed per-button vectors
    localparam int c_idx_up = 0;
    localparam int c_idx_dn = 1;
    localparam int c_idx_ld = 2;

    localparam int c_db_w    = $clog2(DEBOUNCE_CYC + 1);
    localparam int c_tmr_max = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int c_tmr_w   = $clog2(c_tmr_max);

    localparam logic [c_db_w-1:0]  c_db_last      = c_db_w'(DEBOUNCE_CYC - 1);
    localparam logic [c_db_w-1:0]  c_db_one       = c_db_w'(1);
    localparam logic [c_tmr_w-1:0] c_delay_reload = c_tmr_w'(REPEAT_DELAY - 1);
    localparam logic [c_tmr_w-1:0] c_rate_reload  = c_tmr_w'(REPEAT_RATE - 1);
    localparam logic [c_tmr_w-1:0] c_tmr_one      = c_tmr_w'(1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DELAY  = 2'd1,
        ST_REPEAT = 2'd2
    } state_t;

    logic [2:0]        w_btn_raw;
    logic [2:0]        r_btn_s1;
    logic [2:0]        r_btn_s2;
    logic [3:0]        r_sw_s1;
    logic [3:0]        r_sw_s2;
    logic [2:0]        r_deb;
    logic [c_db_w-1:0] r_db_cnt [3];
    logic [2:0]        r_lvl;
    logic [2:0]        r_rise;

    state_t             r_state;
    logic [c_tmr_w-1:0] r_timer;

    logic w_up_lvl;
    logic w_dn_lvl;
    logic w_ld_lvl;
    logic w_up_rise;
    logic w_dn_rise;
    logic w_ld_rise;
    logic w_abort;

    assign w_btn_raw = {btn_load, btn_dn, btn_up};

    // Two-flop synchronizers for every raw button and switch bit
    always_ff @(posedge clk) begin
        if (reset) begin
            r_btn_s1 <= '0;
            r_btn_s2 <= '0;
            r_sw_s1  <= '0;
            r_sw_s2  <= '0;
        end else begin
            r_btn_s1 <= w_btn_raw;
            r_btn_s2 <= r_btn_s1;
            r_sw_s1  <= sw_data;
            r_sw_s2  <= r_sw_s1;
        end
    end

    // Per-button debounce: toggle only after DEBOUNCE_CYC consecutive differing samples
    always_ff @(posedge clk) begin
        if (reset) begin
            r_deb <= '0;
            for (int i = 0; i < 3; i++) begin
                r_db_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (r_btn_s2[i] == r_deb[i]) begin
                    r_db_cnt[i] <= '0;
                end else if (r_db_cnt[i] == c_db_last) begin
                    r_deb[i]    <= ~r_deb[i];
                    r_db_cnt[i] <= '0;
                end else begin
                    r_db_cnt[i] <= r_db_cnt[i] + c_db_one;
                end
            end
        end
    end

    // Registered debounced levels and rising-edge strobes, kept cycle-aligned
    always_ff @(posedge clk) begin
        if (reset) begin
            r_lvl  <= '0;
            r_rise <= '0;
        end else begin
            r_lvl  <= r_deb;
            r_rise <= r_deb & ~r_lvl;
        end
    end

    assign w_up_lvl  = r_lvl[c_idx_up];
    assign w_dn_lvl  = r_lvl[c_idx_dn];
    assign w_ld_lvl  = r_lvl[c_idx_ld];
    assign w_up_rise = r_rise[c_idx_up];
    assign w_dn_rise = r_rise[c_idx_dn];
    assign w_ld_rise = r_rise[c_idx_ld];

    // The held direction is whatever 'up' was set to by the first pulse
    assign w_abort = w_ld_lvl |
                     (up ? (~w_up_lvl | w_dn_lvl) : (~w_dn_lvl | w_up_lvl));

    // Direction FSM with repeat timer; load strobe and data capture share this block
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_timer  <= '0;
            load     <= 1'b0;
            count_en <= 1'b0;
            up       <= 1'b1;
            data_in  <= '0;
        end else begin
            load     <= 1'b0;
            count_en <= 1'b0;

            if (w_ld_rise) begin
                load    <= 1'b1;
                data_in <= r_sw_s2;
            end

            if (w_ld_lvl) begin
                // A held load suppresses counting and cancels any repeat
                r_state <= ST_IDLE;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_up_rise && !w_dn_lvl) begin
                            count_en <= 1'b1;
                            up       <= 1'b1;
                            r_timer  <= c_delay_reload;
                            r_state  <= ST_DELAY;
                        end else if (w_dn_rise && !w_up_lvl) begin
                            count_en <= 1'b1;
                            up       <= 1'b0;
                            r_timer  <= c_delay_reload;
                            r_state  <= ST_DELAY;
                        end
                    end
                    ST_DELAY, ST_REPEAT: begin
                        if (w_abort) begin
                            r_state <= ST_IDLE;
                        end else if (r_timer == '0) begin
                            count_en <= 1'b1;
                            r_timer  <= c_rate_reload;
                            r_state  <= ST_REPEAT;
                        end else begin
                            r_timer <= r_timer - c_tmr_one;
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_counter_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_counter_ctrl
// Description : Self-checking bench for counter_ctrl. Expected strobes are
//               queued with their cycle numbers as stimulus is applied and a
//               monitor pops and compares them as the DUT produces them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_counter_ctrl;

    localparam int DB    = 4;
    localparam int DELAY = 20;
    localparam int RATE  = 5;
    localparam int LAT   = DB + 3;

    logic       clk;
    logic       reset;
    logic       btn_up;
    logic       btn_dn;
    logic       btn_load;
    logic [3:0] sw_data;
    logic       load;
    logic       count_en;
    logic       up;
    logic [3:0] data_in;

    typedef struct {
        int         cyc;
        logic [3:0] val;
    } ev_t;

    ev_t q_cnt[$];
    ev_t q_ld[$];
    ev_t ev_m;

    int checks   = 0;
    int failures = 0;
    int edge_n   = 0;
    bit mon_en   = 0;

    counter_ctrl #(
        .DEBOUNCE_CYC(DB),
        .REPEAT_DELAY(DELAY),
        .REPEAT_RATE (RATE)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .btn_up  (btn_up),
        .btn_dn  (btn_dn),
        .btn_load(btn_load),
        .sw_data (sw_data),
        .load    (load),
        .count_en(count_en),
        .up      (up),
        .data_in (data_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: number each rising edge, sample 1ns later, match against queues
    initial begin
        forever begin
            @(posedge clk);
            edge_n = edge_n + 1;
            #1;
            if (mon_en) begin
                while (q_cnt.size() > 0 && q_cnt[0].cyc < edge_n) begin
                    checks++; failures++;
                    $display("FAIL count_missing: expected count_en at cycle %0d did not occur", q_cnt[0].cyc);
                    void'(q_cnt.pop_front());
                end
                while (q_ld.size() > 0 && q_ld[0].cyc < edge_n) begin
                    checks++; failures++;
                    $display("FAIL load_missing: expected load at cycle %0d did not occur", q_ld[0].cyc);
                    void'(q_ld.pop_front());
                end
                if (count_en !== 1'b0) begin
                    checks++;
                    if (q_cnt.size() == 0 || q_cnt[0].cyc != edge_n) begin
                        failures++;
                        $display("FAIL count_unexpected: count_en=%b at cycle %0d, required 0", count_en, edge_n);
                    end else begin
                        ev_m = q_cnt.pop_front();
                        if (up !== ev_m.val[0]) begin
                            failures++;
                            $display("FAIL count_dir: up=%b at cycle %0d, required %b", up, edge_n, ev_m.val[0]);
                        end
                    end
                end
                if (load !== 1'b0) begin
                    checks++;
                    if (q_ld.size() == 0 || q_ld[0].cyc != edge_n) begin
                        failures++;
                        $display("FAIL load_unexpected: load=%b at cycle %0d, required 0", load, edge_n);
                    end else begin
                        ev_m = q_ld.pop_front();
                        if (data_in !== ev_m.val) begin
                            failures++;
                            $display("FAIL load_data: data_in=%h at cycle %0d, required %h", data_in, edge_n, ev_m.val);
                        end
                    end
                end
                if (count_en === 1'b1 && load === 1'b1) begin
                    checks++; failures++;
                    $display("FAIL strobe_overlap: load and count_en both 1 at cycle %0d", edge_n);
                end
            end
        end
    end

    task automatic push_cnt(input int cyc, input logic dir);
        ev_t e;
        e.cyc = cyc;
        e.val = {3'b000, dir};
        q_cnt.push_back(e);
    endtask

    task automatic push_ld(input int cyc, input logic [3:0] d);
        ev_t e;
        e.cyc = cyc;
        e.val = d;
        q_ld.push_back(e);
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_drained(input string name);
        checks++;
        if (q_cnt.size() != 0 || q_ld.size() != 0) begin
            failures++;
            $display("FAIL %s_drained: pending count=%0d load=%0d, required 0 0", name, q_cnt.size(), q_ld.size());
        end
        q_cnt.delete();
        q_ld.delete();
    endtask

    task automatic test_reset();
        reset = 1'b1; btn_up = 1'b0; btn_dn = 1'b0; btn_load = 1'b0; sw_data = 4'h0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (load !== 1'b0 || count_en !== 1'b0 || up !== 1'b1 || data_in !== 4'h0) begin
                failures++;
                $display("FAIL reset_hold: load=%b count_en=%b up=%b data_in=%h, required 0 0 1 0", load, count_en, up, data_in);
            end
            btn_up = 1'($urandom); btn_dn = 1'($urandom); btn_load = 1'($urandom); sw_data = 4'($urandom);
        end
        @(negedge clk);
        reset = 1'b0; btn_up = 1'b0; btn_dn = 1'b0; btn_load = 1'b0;
        @(negedge clk);
        checks++;
        if (load !== 1'b0 || count_en !== 1'b0 || up !== 1'b1 || data_in !== 4'h0) begin
            failures++;
            $display("FAIL reset_release: load=%b count_en=%b up=%b data_in=%h, required 0 0 1 0", load, count_en, up, data_in);
        end
        mon_en = 1'b1;
    endtask

    task automatic test_single_press();
        int t0;
        t0 = edge_n + 1;
        push_cnt(t0 + LAT, 1'b1);
        btn_up = 1'b1;
        wait_cyc(10);
        btn_up = 1'b0;
        wait_cyc(30);
        test_drained("single");
    endtask

    task automatic test_bounce();
        for (int i = 0; i < 20; i++) begin
            btn_dn = ((i / 2) % 2 == 0);
            @(negedge clk);
            checks++;
            if (dut.r_deb[1] !== 1'b0) begin
                failures++;
                $display("FAIL bounce_level: debounced dn=%b at cycle %0d, required 0", dut.r_deb[1], edge_n);
            end
        end
        btn_dn = 1'b0;
        wait_cyc(20);
        test_drained("bounce");
    endtask

    task automatic test_auto_repeat();
        int t0;
        int t;
        t0 = edge_n + 1;
        push_cnt(t0 + LAT, 1'b0);
        // Repeats continue until the release has propagated to the FSM
        t = t0 + LAT + DELAY;
        while (t < t0 + 60 + LAT) begin
            push_cnt(t, 1'b0);
            t = t + RATE;
        end
        btn_dn = 1'b1;
        wait_cyc(60);
        btn_dn = 1'b0;
        wait_cyc(40);
        test_drained("repeat");
    endtask

    task automatic test_load_priority();
        int t0;
        sw_data = 4'hA;
        wait_cyc(5);
        t0 = edge_n + 1;
        push_ld(t0 + LAT, 4'hA);
        btn_load = 1'b1;
        btn_up   = 1'b1;
        wait_cyc(15);
        sw_data  = 4'h5;
        btn_load = 1'b0;
        wait_cyc(40);
        btn_up = 1'b0;
        wait_cyc(20);
        checks++;
        if (data_in !== 4'hA) begin
            failures++;
            $display("FAIL load_hold: data_in=%h, required a", data_in);
        end
        test_drained("load");
    endtask

    task automatic test_conflict();
        int t0;
        int t;
        t0 = edge_n + 1;
        push_cnt(t0 + LAT, 1'b1);
        // dn rises at t0+30; the abort reaches the FSM LAT cycles later
        t = t0 + LAT + DELAY;
        while (t < t0 + 30 + LAT) begin
            push_cnt(t, 1'b1);
            t = t + RATE;
        end
        btn_up = 1'b1;
        wait_cyc(30);
        btn_dn = 1'b1;
        wait_cyc(30);
        btn_up = 1'b0;
        btn_dn = 1'b0;
        wait_cyc(20);
        test_drained("conflict");
    endtask

    task automatic test_midhold_reset();
        int t0;
        int t1;
        t0 = edge_n + 1;
        push_cnt(t0 + LAT, 1'b1);
        btn_up = 1'b1;
        wait_cyc(12);
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (load !== 1'b0 || count_en !== 1'b0 || up !== 1'b1 || data_in !== 4'h0) begin
            failures++;
            $display("FAIL midhold_reset: load=%b count_en=%b up=%b data_in=%h, required 0 0 1 0", load, count_en, up, data_in);
        end
        reset = 1'b0;
        t1 = edge_n + 1;
        push_cnt(t1 + LAT, 1'b1);
        wait_cyc(15);
        btn_up = 1'b0;
        wait_cyc(30);
        test_drained("midhold");
    endtask

    initial begin
        test_reset();
        test_single_press();
        test_bounce();
        test_auto_repeat();
        test_load_priority();
        test_conflict();
        test_midhold_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
